// File: rtl/boss_hp_ctrl_pkg.sv
// rtl/boss_hp_ctrl_pkg.sv - shared boss HP encodings, thresholds and phase decode
package boss_hp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_FIGHT  = 2'd1,
    ST_INVULN = 2'd2,
    ST_DEAD   = 2'd3
  } state_e;

  localparam int HP_W         = 10;
  localparam int COORD_W      = 10;
  // Shared with the movement stage so its boss-present window (0 < HP < 451) lines up.
  localparam int BOSS_HP_INIT = 450;
  localparam int PHASE1_TH    = 300;
  localparam int PHASE2_TH    = 150;

  // Phase bands: 0 above 300, 1 for 151..300, 2 for 1..150, 3 at zero.
  function automatic logic [1:0] phase_of(input logic [HP_W-1:0] hp);
    if (hp > HP_W'(PHASE1_TH))      return 2'd0;
    else if (hp > HP_W'(PHASE2_TH)) return 2'd1;
    else if (hp != '0)              return 2'd2;
    else                            return 2'd3;
  endfunction

endpackage

// File: rtl/boss_hp_ctrl_if.sv
// rtl/boss_hp_ctrl_if.sv - boss position/bullet inputs and HP status outputs
interface boss_hp_ctrl_if;
  import boss_hp_ctrl_pkg::*;

  logic               boss;
  logic [COORD_W-1:0] bossx;
  logic [COORD_W-1:0] bossy;
  logic               bullet_valid;
  logic [COORD_W-1:0] bulletx;
  logic [COORD_W-1:0] bullety;
  logic [HP_W-1:0]    bosshp;
  logic [1:0]         phase;
  logic               hit_flash;
  logic               bullet_hit;
  logic               boss_dead;

  modport master (
    output boss, bossx, bossy, bullet_valid, bulletx, bullety,
    input  bosshp, phase, hit_flash, bullet_hit, boss_dead
  );

  modport slave (
    input  boss, bossx, bossy, bullet_valid, bulletx, bullety,
    output bosshp, phase, hit_flash, bullet_hit, boss_dead
  );

endinterface

// File: rtl/boss_hitbox.sv
// rtl/boss_hitbox.sv - combinational point-in-box compare with exclusive right/bottom edges
module boss_hitbox
  import boss_hp_ctrl_pkg::*;
#(
  parameter int W = 100,
  parameter int H = 60
) (
  input  logic               valid_i,
  input  logic               en_i,
  input  logic [COORD_W-1:0] boxx_i,
  input  logic [COORD_W-1:0] boxy_i,
  input  logic [COORD_W-1:0] ptx_i,
  input  logic [COORD_W-1:0] pty_i,
  output logic               hit_o
);

  logic [COORD_W:0] right_edge;
  logic [COORD_W:0] bottom_edge;

  // Edges are one bit wider than coordinates so a box near 1023 never wraps.
  always_comb begin
    right_edge  = {1'b0, boxx_i} + (COORD_W+1)'(W);
    bottom_edge = {1'b0, boxy_i} + (COORD_W+1)'(H);
    hit_o = valid_i && en_i
         && (ptx_i >= boxx_i) && ({1'b0, ptx_i} < right_edge)
         && (pty_i >= boxy_i) && ({1'b0, pty_i} < bottom_edge);
  end

endmodule

// File: rtl/boss_hp_ctrl.sv
// rtl/boss_hp_ctrl.sv - boss hit-point FSM with post-hit invulnerability window
module boss_hp_ctrl
  import boss_hp_ctrl_pkg::*;
#(
  parameter int HP_INIT    = BOSS_HP_INIT,
  parameter int DMG        = 10,
  parameter int BOSS_W     = 100,
  parameter int BOSS_H     = 60,
  parameter int INVULN_CYC = 8
) (
  input logic           clk22,
  input logic           rst,
  boss_hp_ctrl_if.slave bus
);

  localparam int CW = (INVULN_CYC > 2) ? $clog2(INVULN_CYC) : 1;

  state_e            state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        phase_q;
  logic              flash_q;
  logic              bhit_q, bhit_d;
  logic              dead_q;
  logic              hit;

  // boss is part of the hit term, so boss==0 in FIGHT can never also be a hit.
  boss_hitbox #(.W(BOSS_W), .H(BOSS_H)) u_hitbox (
    .valid_i (bus.bullet_valid),
    .en_i    (bus.boss),
    .boxx_i  (bus.bossx),
    .boxy_i  (bus.bossy),
    .ptx_i   (bus.bulletx),
    .pty_i   (bus.bullety),
    .hit_o   (hit)
  );

  // Next-state, HP and invulnerability counter; hits only count in FIGHT.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    bhit_d  = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (bus.boss) state_d = ST_FIGHT;
      end
      ST_FIGHT: begin
        if (hit) begin
          bhit_d = 1'b1;
          hp_d   = (hp_q > HP_W'(DMG)) ? hp_q - HP_W'(DMG) : '0;
          if (hp_d == '0) begin
            state_d = ST_DEAD;
          end else begin
            state_d = ST_INVULN;
            cnt_d   = CW'(INVULN_CYC - 1);
          end
        end else if (!bus.boss) begin
          state_d = ST_WAIT;
        end
      end
      ST_INVULN: begin
        if (!bus.boss) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_FIGHT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DEAD: begin
        hp_d = '0;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state so they align with bosshp.
  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q <= ST_WAIT;
      hp_q    <= HP_W'(HP_INIT);
      cnt_q   <= '0;
      phase_q <= phase_of(HP_W'(HP_INIT));
      flash_q <= 1'b0;
      bhit_q  <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_of(hp_d);
      flash_q <= (state_d == ST_INVULN);
      bhit_q  <= bhit_d;
      dead_q  <= (state_d == ST_DEAD);
    end
  end

  assign bus.bosshp     = hp_q;
  assign bus.phase      = phase_q;
  assign bus.hit_flash  = flash_q;
  assign bus.bullet_hit = bhit_q;
  assign bus.boss_dead  = dead_q;

endmodule
